// File: rtl/hit_judge_pkg.sv
// hit_judge_pkg: shared definitions for the reaction-game round judge.
//   - fsm_t      : round sequencer states (IDLE/GAP/SHOW)
//   - window_ms  : response window length in ticks per difficulty level
//   - lfsr_step  : one step of the target-selection LFSR (x^8+x^6+x^5+x^4+1)
//   - onehot4    : 2-bit index to one-hot lamp pattern
package hit_judge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2
    } fsm_t;

    // Width of the millisecond tick counter (covers both GAP_MS and windows).
    localparam int MS_W = 16;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Fibonacci taps at bits 7,5,4,3 for x^8+x^6+x^5+x^4+1.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [MS_W-1:0] window_ms(input logic [1:0] lvl);
        logic [MS_W-1:0] w;
        case (lvl)
            2'd0:    w = 16'd800;
            2'd1:    w = 16'd600;
            2'd2:    w = 16'd400;
            default: w = 16'd250;
        endcase
        return w;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/hit_judge_if.sv
// hit_judge_if: player/control inputs and round-result outputs of hit_judge.
//   master : drives btn, start, stop, level; observes the results
//   slave  : the judge itself
//   btn[3:0]   raw player buttons (async, active-high)
//   start/stop one-cycle play control pulses
//   level[1:0] difficulty, sampled once per round
//   lamp[3:0]  one-hot target lamp (0 when dark)
//   evt        one-cycle round-result pulse
//   key        1 = hit, 0 = miss (held after evt)
//   state[1:0] level in force for the judged round
//   busy       play running
interface hit_judge_if;
    logic [3:0] btn;
    logic       start;
    logic       stop;
    logic [1:0] level;
    logic [3:0] lamp;
    logic       evt;
    logic       key;
    logic [1:0] state;
    logic       busy;

    modport master (
        output btn, start, stop, level,
        input  lamp, evt, key, state, busy
    );

    modport slave (
        input  btn, start, stop, level,
        output lamp, evt, key, state, busy
    );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus stability counter for one button.
//   clk, rst_n : clock, async active-low reset
//   raw        : asynchronous button input
//   level      : debounced level, flips after DB_CYCLES consecutive clocks
//                of the synchronized input disagreeing with it
//   rise       : registered one-cycle pulse on a debounced 0->1 change,
//                asserted in the same cycle the new level appears
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;
    logic          flip;

    assign flip = (sync2 != level) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any agreement restarts the stability count.
            if (sync2 == level || flip) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (flip) begin
                level <= sync2;
            end
            rise <= flip && sync2;
        end
    end

endmodule

// File: rtl/hit_judge.sv
// hit_judge: runs the reaction game round by round and judges each round.
//   clk, rst_n : clock, async active-low reset
//   bus        : hit_judge_if.slave (buttons, start/stop, level in;
//                lamp, evt, key, state, busy out)
// Each round: dark GAP of GAP_MS ticks, then SHOW lights a pseudo-random
// target (never the same as the previous one) for a level-dependent window.
// The first debounced press, or window expiry, ends the round with evt.
module hit_judge #(
    parameter int DB_CYCLES   = 500000,
    parameter int TICK_CYCLES = 50000,
    parameter int GAP_MS      = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    hit_judge_if.slave  bus
);

    import hit_judge_pkg::*;

    localparam int CYC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TICK_CYCLES - 1);
    localparam logic [MS_W-1:0]  GAP_LAST = MS_W'(GAP_MS - 1);

    fsm_t             state_q, state_d;
    logic [CYC_W-1:0] cyc_q;
    logic [MS_W-1:0]  ms_q;
    logic [7:0]       lfsr_q;
    logic [1:0]       tgt_q, tgt_d;
    logic [1:0]       lvl_q, lvl_d;
    logic [1:0]       pick;
    logic             evt_q, evt_d;
    logic             key_q, key_d;
    logic [3:0]       deb_level, rise, edges, tgt_mask;
    logic             tick_last, gap_done, win_done, tgt_rise, wrong_rise;

    for (genvar g = 0; g < 4; g++) begin : g_deb
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (bus.btn[g]),
            .level (deb_level[g]),
            .rise  (rise[g])
        );
    end

    // A rise pulse is only trusted while the debounced level agrees with it.
    assign edges      = rise & deb_level;
    assign tgt_mask   = onehot4(tgt_q);
    assign tgt_rise   = |(edges & tgt_mask);
    assign wrong_rise = |(edges & ~tgt_mask);

    assign tick_last = (cyc_q == CYC_LAST);
    assign gap_done  = tick_last && (ms_q == GAP_LAST);
    assign win_done  = tick_last && (ms_q == window_ms(lvl_q) - MS_W'(1));

    // tgt_q doubles as the previous index: bump a repeat to the next lamp.
    assign pick = (lfsr_q[1:0] == tgt_q) ? lfsr_q[1:0] + 2'd1 : lfsr_q[1:0];

    always_comb begin
        state_d = state_q;
        evt_d   = 1'b0;
        key_d   = key_q;
        lvl_d   = lvl_q;
        tgt_d   = tgt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_d = SHOW;
                    lvl_d   = bus.level;
                    tgt_d   = pick;
                end
            end
            SHOW: begin
                // Any wrong edge spoils the round; a target edge on the
                // expiry cycle still counts as a hit.
                if (wrong_rise || tgt_rise || win_done) begin
                    state_d = GAP;
                    evt_d   = 1'b1;
                    key_d   = tgt_rise && !wrong_rise;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.stop) begin
            state_d = IDLE;
            evt_d   = 1'b0;
            key_d   = 1'b0;
            lvl_d   = '0;
            tgt_d   = tgt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            ms_q    <= '0;
            lfsr_q  <= LFSR_SEED;
            tgt_q   <= '0;
            lvl_q   <= '0;
            evt_q   <= 1'b0;
            key_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_step(lfsr_q);
            tgt_q   <= tgt_d;
            lvl_q   <= lvl_d;
            evt_q   <= evt_d;
            key_q   <= key_d;
            // Timebase restarts on every state entry and idles in IDLE.
            if (state_d != state_q || state_q == IDLE) begin
                cyc_q <= '0;
                ms_q  <= '0;
            end else if (tick_last) begin
                cyc_q <= '0;
                ms_q  <= ms_q + MS_W'(1);
            end else begin
                cyc_q <= cyc_q + CYC_W'(1);
            end
        end
    end

    assign bus.lamp  = (state_q == SHOW) ? tgt_mask : 4'b0000;
    assign bus.evt   = evt_q;
    assign bus.key   = key_q;
    assign bus.state = lvl_q;
    assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_hit_judge.sv
module tb_hit_judge;

    localparam int DB   = 4;
    localparam int TICK = 10;
    localparam int GAP  = 5;
    localparam int PL   = 2 + DB + 1;   // raw press -> evt latency
    localparam int GAP_CLK = GAP * TICK;

    localparam int K_NONE   = 0;
    localparam int K_TARGET = 1;
    localparam int K_OTHER  = 2;
    localparam int K_BOTH   = 3;

    typedef struct {
        logic [1:0] lvl;
        int         kind;
        int         press_at;
        logic       exp_key;
        int         exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    hit_judge_if bus();

    hit_judge #(.DB_CYCLES(DB), .TICK_CYCLES(TICK), .GAP_MS(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference LFSR: x^8+x^6+x^5+x^4+1 from seed 0xA5, one step per clock.
    function automatic int lfsr_next(input int x);
        int fb;
        fb = ((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1;
        return ((x << 1) | fb) & 255;
    endfunction

    int m_lfsr, m_prev_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr      <= 'hA5;
            m_prev_lfsr <= 'hA5;
        end else begin
            m_prev_lfsr <= m_lfsr;
            m_lfsr      <= lfsr_next(m_lfsr);
        end
    end

    int evt_count  = 0;
    int evt_double = 0;
    bit evt_prev   = 1'b0;
    always @(negedge clk) begin
        if (bus.evt === 1'b1) begin
            evt_count <= evt_count + 1;
            if (evt_prev) evt_double <= evt_double + 1;
        end
        evt_prev <= (bus.evt === 1'b1);
    end

    int         m_last    = 0;
    logic [3:0] last_lamp = 4'b0001;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_evt(input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.evt !== 1'b1 && n < maxc);
        if (bus.evt !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL evt_timeout: got no evt within %0d cycles", maxc);
        end
    endtask

    task automatic begin_round(input logic [1:0] lvl, input bit chk_gap, output int tgt);
        int n, raw, idx;
        bus.level = lvl;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.lamp == 4'b0000 && n < 200);
        check("show_seen", int'(bus.lamp != 4'b0000), 1);
        raw = m_prev_lfsr & 3;
        idx = (raw == m_last) ? (raw + 1) % 4 : raw;
        if (chk_gap) check("gap_len", n, GAP_CLK);
        check("lamp", int'(bus.lamp), 1 << idx);
        check("no_repeat", int'(bus.lamp != last_lamp), 1);
        check("state", int'(bus.state), int'(lvl));
        m_last    = idx;
        last_lamp = bus.lamp;
        tgt       = idx;
    endtask

    task automatic run_round(input vec_t v, input bit chk_gap);
        int t, n, lat;
        logic [3:0] b;
        begin_round(v.lvl, chk_gap, t);
        lat = 0;
        if (v.kind != K_NONE) begin
            step(v.press_at);
            lat = v.press_at;
            b = '0;
            if (v.kind != K_OTHER)  b[t] = 1'b1;
            if (v.kind != K_TARGET) b[(t + 2) % 4] = 1'b1;
            bus.btn = b;
        end
        wait_evt(9000, n);
        check("latency", lat + n, v.exp_lat);
        check("key", int'(bus.key), int'(v.exp_key));
        check("lamp_off", int'(bus.lamp), 0);
        check("busy_round", int'(bus.busy), 1);
        bus.btn = '0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lamp"},  int'(bus.lamp), 0);
        check({tag, "_evt"},   int'(bus.evt), 0);
        check({tag, "_key"},   int'(bus.key), 0);
        check({tag, "_state"}, int'(bus.state), 0);
        check({tag, "_busy"},  int'(bus.busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vec_t v;
        int t, n, c0;

        vecs[0] = '{2'd3, K_TARGET, 100 * TICK,     1'b1, 100 * TICK + PL};
        vecs[1] = '{2'd0, K_NONE,   0,              1'b0, 800 * TICK};
        vecs[2] = '{2'd1, K_BOTH,   20,             1'b0, 20 + PL};
        vecs[3] = '{2'd3, K_TARGET, 250 * TICK - PL, 1'b1, 250 * TICK};
        vecs[4] = '{2'd2, K_OTHER,  5,              1'b0, 5 + PL};
        vecs[5] = '{2'd2, K_TARGET, 400 * TICK - PL + 1, 1'b0, 400 * TICK};
        vecs[6] = '{2'd1, K_TARGET, 0,              1'b1, PL};

        bus.btn = '0; bus.start = 1'b0; bus.stop = 1'b0; bus.level = 2'd0;

        // Reset state
        step(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step(3);
        check("idle_busy", int'(bus.busy), 0);

        // Start, then table-driven rounds
        pulse_start();
        for (int i = 0; i < 7; i++) run_round(vecs[i], 1'b1);

        // Bounce: toggles every 2 clocks then holds -> single hit
        begin_round(2'd3, 1'b1, t);
        step(10);
        c0 = evt_count;
        for (int i = 0; i < 10; i++) begin
            bus.btn[t] = ~bus.btn[t];
            step(2);
        end
        check("bounce_quiet", evt_count - c0, 0);
        bus.btn[t] = 1'b1;
        wait_evt(100, n);
        check("bounce_lat", n, PL);
        check("bounce_key", int'(bus.key), 1);
        bus.btn = '0;
        step(30);
        check("bounce_single", evt_count - c0, 1);

        // All buttons pressed during GAP and held across SHOW entry -> expiry miss
        bus.btn = 4'hF;
        begin_round(2'd3, 1'b0, t);
        wait_evt(3000, n);
        check("held_lat", n, 250 * TICK);
        check("held_key", int'(bus.key), 0);
        bus.btn = '0;

        // Randomized rounds against the model
        for (int r = 0; r < 40; r++) begin
            v.lvl      = 2'($urandom_range(0, 3));
            v.kind     = 1 + int'($urandom_range(0, 2));
            v.press_at = int'($urandom_range(0, 40));
            v.exp_key  = (v.kind == K_TARGET);
            v.exp_lat  = v.press_at + PL;
            run_round(v, 1'b1);
        end

        // Stop mid-SHOW, coinciding with a target edge
        begin_round(2'd2, 1'b1, t);
        step(100);
        bus.btn[t] = 1'b1;
        step(PL - 1);
        c0 = evt_count;
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        check_reset_outputs("stop");
        step(20);
        check("stop_no_evt", evt_count - c0, 0);
        check("stop_idle", int'(bus.busy), 0);
        bus.btn = '0;
        step(10);

        // Restart, one hit, then async reset mid-GAP
        pulse_start();
        v = '{2'd3, K_TARGET, 3, 1'b1, 3 + PL};
        run_round(v, 1'b1);
        step(20);
        c0 = evt_count;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        step(3);
        rst_n = 1'b1;
        m_last    = 0;
        last_lamp = 4'b0001;
        step(100);
        check("rst_no_evt", evt_count - c0, 0);
        check("rst_idle", int'(bus.busy), 0);

        // First round after reset: LFSR and previous index restarted
        pulse_start();
        v = '{2'd1, K_TARGET, 10, 1'b1, 10 + PL};
        run_round(v, 1'b1);

        check("evt_pulse_width", evt_double, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
